// File: rtl/qtree_pkg.sv
// -----------------------------------------------------------------------------
// qtree_pkg -- shared definitions for the search tree and its leaf stage.
//
// Holds the tree-wide default widths, the leaf-table entry layout and the
// leaf result record. qleaf and its interface take their parameter defaults
// from here.
// -----------------------------------------------------------------------------
package qtree_pkg;

    // Leaf address width, equal to NEXT_A_WIDTH of the final tree stage.
    localparam int unsigned LEAF_A_WIDTH = 8;
    localparam int unsigned KEY_WIDTH    = 16;
    localparam int unsigned VALUE_WIDTH  = 16;

    typedef struct packed {
        logic                   vld;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } leaf_entry_t;

    typedef struct packed {
        logic                    hit;
        logic [KEY_WIDTH-1:0]    key;
        logic [VALUE_WIDTH-1:0]  value;
        logic [LEAF_A_WIDTH-1:0] addr;
    } qleaf_result_t;

endpackage

// File: rtl/qleaf_if.sv
// -----------------------------------------------------------------------------
// qleaf_if -- valid/ready result stream leaving the leaf stage.
//
// Signals: res_valid_o, res_hit_o, res_key_o, res_value_o, res_addr_o
//          (driven by the master), res_ready_i (driven by the slave).
// Modports: master (qleaf), slave (downstream consumer).
// -----------------------------------------------------------------------------
interface qleaf_if
    import qtree_pkg::*;
#(
    parameter int unsigned A_WIDTH = LEAF_A_WIDTH,
    parameter int unsigned D_WIDTH = KEY_WIDTH,
    parameter int unsigned V_WIDTH = VALUE_WIDTH
);
    logic               res_valid_o;
    logic               res_ready_i;
    logic               res_hit_o;
    logic [D_WIDTH-1:0] res_key_o;
    logic [V_WIDTH-1:0] res_value_o;
    logic [A_WIDTH-1:0] res_addr_o;

    modport master (
        output res_valid_o, res_hit_o, res_key_o, res_value_o, res_addr_o,
        input  res_ready_i
    );

    modport slave (
        input  res_valid_o, res_hit_o, res_key_o, res_value_o, res_addr_o,
        output res_ready_i
    );
endinterface

// File: rtl/qleaf_fifo.sv
// -----------------------------------------------------------------------------
// qleaf_fifo -- show-ahead result FIFO of the leaf stage.
//
// Ports: clk, rst (async, active-high), push/push_data, pop, pop_data
//        (head word, zero while empty), empty, accepted (push stored this
//        cycle), drop (push lost because full with no pop).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// There is no empty bypass: a word is always written before it is visible.
// -----------------------------------------------------------------------------
module qleaf_fifo #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             accepted,
    output logic             drop
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             full;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign accepted = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;

    // Zeroed while empty so the result fields read 0 out of reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accepted) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({accepted, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/simple_ram.sv
// -----------------------------------------------------------------------------
// simple_ram -- one write port, one synchronous read port.
//
// Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr (read address, sampled
//        every cycle), rd_data (registered read data, one cycle later).
// A read and write to the same address in one cycle returns the old word.
// -----------------------------------------------------------------------------
module simple_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: storage arrays carry no reset so they map onto RAM macros; any
    // state that must be known after reset lives in separate valid flags.
    // NOTE: non-blocking assignments make the read below see the pre-write
    // word on an address collision, which is the read-old behaviour we want.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/qleaf.sv
// -----------------------------------------------------------------------------
// qleaf -- final leaf stage of the search tree.
//
// Reads the leaf entry addressed by the last tree stage, compares its key with
// the search key and queues {hit, key, value, addr} into a show-ahead FIFO.
// Latency request -> res_valid_o is 3 cycles; one request per cycle.
//
// Ports: clk_i, rst_i (async, active-high)
//        lookup_en_i/lookup_addr_i/lookup_data_i  leaf request, no backpressure
//        wr_en_i/wr_addr_i/wr_data_i              leaf-table write
//        res (qleaf_if.master)                    result stream
//        overflow_o                               sticky result-drop flag
//        stats_clr_i, hit_cnt_o, miss_cnt_o, drop_cnt_o  statistics
// Build option: define QLEAF_STATS_EN to instantiate the saturating counters;
// otherwise the three counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module qleaf
    import qtree_pkg::*;
#(
    parameter int unsigned A_WIDTH    = LEAF_A_WIDTH,
    parameter int unsigned D_WIDTH    = KEY_WIDTH,
    parameter int unsigned V_WIDTH    = VALUE_WIDTH,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     lookup_en_i,
    input  logic [A_WIDTH-1:0]       lookup_addr_i,
    input  logic [D_WIDTH-1:0]       lookup_data_i,
    input  logic                     wr_en_i,
    input  logic [A_WIDTH-1:0]       wr_addr_i,
    input  logic [$bits(leaf_entry_t)-1:0] wr_data_i,
    qleaf_if.master                  res,
    output logic                     overflow_o,
    input  logic                     stats_clr_i,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o,
    output logic [31:0]              drop_cnt_o
);
    logic [$bits(leaf_entry_t)-1:0] ram_rd_data;
    leaf_entry_t                    entry;
    logic                           s1_valid;
    logic [D_WIDTH-1:0]             s1_key;
    logic [A_WIDTH-1:0]             s1_addr;
    logic                           s2_valid;
    qleaf_result_t                  s2_result;
    qleaf_result_t                  head;
    logic                           fifo_empty;
    logic                           fifo_accepted;
    logic                           fifo_drop;

    simple_ram #(
        .ADDR_WIDTH (A_WIDTH),
        .DATA_WIDTH ($bits(leaf_entry_t))
    ) u_leaf_ram (
        .clk     (clk_i),
        .wr_en   (wr_en_i),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (lookup_addr_i),
        .rd_data (ram_rd_data)
    );

    assign entry = leaf_entry_t'(ram_rd_data);

    // Stage 1: key/address travel alongside the RAM read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_key   <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= lookup_en_i;
            s1_key   <= lookup_data_i;
            s1_addr  <= lookup_addr_i;
        end
    end

    // Stage 2: registered compare result; value is forced to 0 on a miss.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else begin
            s2_valid        <= s1_valid;
            s2_result.hit   <= entry.vld && (entry.key == s1_key);
            s2_result.key   <= s1_key;
            s2_result.value <= (entry.vld && (entry.key == s1_key)) ? entry.value : '0;
            s2_result.addr  <= s1_addr;
        end
    end

    qleaf_fifo #(
        .WIDTH ($bits(qleaf_result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (s2_valid),
        .push_data (s2_result),
        .pop       (res.res_ready_i),
        .pop_data  (head),
        .empty     (fifo_empty),
        .accepted  (fifo_accepted),
        .drop      (fifo_drop)
    );

    assign res.res_valid_o = !fifo_empty;
    assign res.res_hit_o   = head.hit;
    assign res.res_key_o   = head.key;
    assign res.res_value_o = head.value;
    assign res.res_addr_o  = head.addr;

    // Clear beats a same-cycle drop so software never misses the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (stats_clr_i) begin
            overflow_o <= 1'b0;
        end else if (fifo_drop) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef QLEAF_STATS_EN
    logic hit_inc;
    logic miss_inc;

    assign hit_inc  = fifo_accepted && s2_result.hit;
    assign miss_inc = fifo_accepted && !s2_result.hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else if (stats_clr_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (hit_inc  && (hit_cnt_o  != '1)) hit_cnt_o  <= hit_cnt_o  + 1'b1;
            if (miss_inc && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 1'b1;
            if (fifo_drop && (drop_cnt_o != '1)) drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
    assign drop_cnt_o = '0;
`endif

endmodule
